// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I-subset controller: Moore FSM with embedded ALU decoder; outputs decode combinationally from state.
// FETCH, MEMREAD and MEMWRITE hold until mem_ready; every output is forced low while rst_n is low.
module multicycle_control_fsm #(
  parameter int STATE_W   = 4,
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pcwrite,
  output logic                 adrsrc,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regwrite,
  output logic [1:0]           resultsrc,
  output logic [1:0]           alusrca,
  output logic [1:0]           alusrcb,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal,
  output logic [STATE_W-1:0]   state_dbg
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t     state;
  logic [1:0] aluop;
  logic [2:0] alu_dec;
  logic       op_known;

  assign op_known = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_R) ||
                    (opcode == OP_I) || (opcode == OP_BEQ) || (opcode == OP_JAL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXECR;
            OP_I:         state <= S_EXECI;
            OP_BEQ:       state <= S_BEQ;
            OP_JAL:       state <= S_JAL;
            default:      state <= S_FETCH;
          endcase
        end
        // IR still holds the instruction, so opcode picks load vs store here
        S_MEMADR:   state <= (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECR, S_EXECI, S_JAL:   state <= S_ALUWB;
        S_MEMWB, S_ALUWB, S_BEQ:   state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pcwrite   = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    aluop     = 2'b00;
    illegal   = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          alusrcb   = 2'b10;
          resultsrc = 2'b10;
          irwrite   = mem_ready;
          pcwrite   = mem_ready;
        end
        S_DECODE: begin
          alusrca = 2'b01;
          alusrcb = 2'b01;
          illegal = !op_known;
        end
        S_MEMADR: begin
          alusrca = 2'b10;
          alusrcb = 2'b01;
        end
        S_MEMREAD:  adrsrc = 1'b1;
        S_MEMWB: begin
          resultsrc = 2'b01;
          regwrite  = 1'b1;
        end
        S_MEMWRITE: begin
          adrsrc   = 1'b1;
          memwrite = 1'b1;
        end
        S_EXECR: begin
          alusrca = 2'b10;
          aluop   = 2'b10;
        end
        S_EXECI: begin
          alusrca = 2'b10;
          alusrcb = 2'b01;
          aluop   = 2'b10;
        end
        S_ALUWB:    regwrite = 1'b1;
        S_BEQ: begin
          alusrca = 2'b10;
          aluop   = 2'b01;
          pcwrite = zero;
        end
        S_JAL: begin
          alusrca = 2'b01;
          alusrcb = 2'b10;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // opcode[5] separates R-type sub from I-type addi, which has no funct7
  always_comb begin
    alu_dec = 3'b000;
    case (aluop)
      2'b01: alu_dec = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_dec = (opcode[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b110:  alu_dec = 3'b011;
          3'b111:  alu_dec = 3'b010;
          default: alu_dec = 3'b000;
        endcase
      end
      default: alu_dec = 3'b000;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(alu_dec);
  assign state_dbg  = rst_n ? STATE_W'(state) : '0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle expected outputs queued and compared at the falling edge.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] ac;
    logic       ill;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb;
  logic [2:0] alucontrol;
  logic [3:0] state_dbg;

  out_t  obs;
  out_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    passes = 0;

  multicycle_control_fsm #(.STATE_W(4), .ALUCTRL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite), .adrsrc(adrsrc),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .resultsrc(resultsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always_comb begin
    obs = '{st: state_dbg, pcw: pcwrite, adr: adrsrc, mw: memwrite, irw: irwrite,
            rw: regwrite, rs: resultsrc, sa: alusrca, sb: alusrcb, ac: alucontrol, ill: illegal};
  end

  function automatic out_t o(input logic [3:0] st, input logic [1:0] sa, sb, rs,
                             input logic [2:0] ac, input logic pcw, adr, mw, irw, rw, ill);
    out_t r;
    r.st = st; r.sa = sa; r.sb = sb; r.rs = rs; r.ac = ac;
    r.pcw = pcw; r.adr = adr; r.mw = mw; r.irw = irw; r.rw = rw; r.ill = ill;
    return r;
  endfunction

  function automatic out_t e_fetch(input logic mr);  return o(4'd0, 2'b00, 2'b10, 2'b10, 3'b000, mr, 0, 0, mr, 0, 0); endfunction
  function automatic out_t e_decode(input logic il); return o(4'd1, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0, 0, 0, 0, il); endfunction
  function automatic out_t e_memadr();               return o(4'd2, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0); endfunction
  function automatic out_t e_memread();              return o(4'd3, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1, 0, 0, 0, 0); endfunction
  function automatic out_t e_memwb();                return o(4'd4, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0, 0, 0, 1, 0); endfunction
  function automatic out_t e_memwrite();             return o(4'd5, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1, 1, 0, 0, 0); endfunction
  function automatic out_t e_execr(input logic [2:0] ac); return o(4'd6, 2'b10, 2'b00, 2'b00, ac, 0, 0, 0, 0, 0, 0); endfunction
  function automatic out_t e_execi(input logic [2:0] ac); return o(4'd7, 2'b10, 2'b01, 2'b00, ac, 0, 0, 0, 0, 0, 0); endfunction
  function automatic out_t e_aluwb();                return o(4'd8, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0, 0, 1, 0); endfunction
  function automatic out_t e_beq(input logic pc);    return o(4'd9, 2'b10, 2'b00, 2'b00, 3'b001, pc, 0, 0, 0, 0, 0); endfunction
  function automatic out_t e_jal();                  return o(4'd10, 2'b01, 2'b10, 2'b00, 3'b000, 1, 0, 0, 0, 0, 0); endfunction

  // Queue the expectation for this cycle, compare at the falling edge, then move past the next rising edge.
  task automatic cyc(input string tag, input out_t e);
    out_t  want;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    checks++;
    assert (obs === want) passes++;
    else $error("FAIL %s: observed %h expected %h", t, obs, want);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7b5 = f7;
  endtask

  initial begin
    rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    set_instr(7'b0000011, 3'b010, 1'b0);
    @(posedge clk); #1;
    cyc("reset_idle", '0);
    rst_n = 1'b1;

    // lw with one MEMREAD stall
    cyc("lw_fetch", e_fetch(1));
    cyc("lw_decode", e_decode(0));
    cyc("lw_memadr", e_memadr());
    mem_ready = 1'b0;
    cyc("lw_memread_stall", e_memread());
    mem_ready = 1'b1;
    cyc("lw_memread", e_memread());
    cyc("lw_memwb", e_memwb());

    set_instr(7'b0110011, 3'b000, 1'b1);
    cyc("sub_fetch", e_fetch(1));
    cyc("sub_decode", e_decode(0));
    cyc("sub_execr", e_execr(3'b001));
    cyc("sub_aluwb", e_aluwb());

    set_instr(7'b0010011, 3'b000, 1'b1);
    cyc("addi_fetch", e_fetch(1));
    cyc("addi_decode", e_decode(0));
    cyc("addi_execi", e_execi(3'b000));
    cyc("addi_aluwb", e_aluwb());

    set_instr(7'b0110011, 3'b111, 1'b0);
    cyc("and_fetch", e_fetch(1));
    cyc("and_decode", e_decode(0));
    cyc("and_execr", e_execr(3'b010));
    cyc("and_aluwb", e_aluwb());

    set_instr(7'b0010011, 3'b110, 1'b0);
    cyc("ori_fetch", e_fetch(1));
    cyc("ori_decode", e_decode(0));
    cyc("ori_execi", e_execi(3'b011));
    cyc("ori_aluwb", e_aluwb());

    set_instr(7'b1100011, 3'b000, 1'b0);
    zero = 1'b1;
    cyc("beq_t_fetch", e_fetch(1));
    cyc("beq_t_decode", e_decode(0));
    cyc("beq_t_beq", e_beq(1));

    // zero high outside BEQ must not move the PC
    cyc("beq_n_fetch", e_fetch(1));
    cyc("beq_n_decode_zero_glitch", e_decode(0));
    zero = 1'b0;
    cyc("beq_n_beq", e_beq(0));

    set_instr(7'b1101111, 3'b000, 1'b0);
    cyc("jal_fetch", e_fetch(1));
    cyc("jal_decode", e_decode(0));
    cyc("jal_jal", e_jal());
    cyc("jal_aluwb", e_aluwb());

    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("sw_fetch", e_fetch(1));
    cyc("sw_decode", e_decode(0));
    cyc("sw_memadr", e_memadr());
    mem_ready = 1'b0;
    cyc("sw_memwrite_stall1", e_memwrite());
    cyc("sw_memwrite_stall2", e_memwrite());
    mem_ready = 1'b1;
    cyc("sw_memwrite_done", e_memwrite());
    mem_ready = 1'b0;
    cyc("fetch_stall1", e_fetch(0));
    cyc("fetch_stall2", e_fetch(0));
    mem_ready = 1'b1;

    set_instr(7'b1110011, 3'b000, 1'b0);
    cyc("ill_fetch", e_fetch(1));
    cyc("ill_decode", e_decode(1));

    // reset in the middle of a MEMWRITE stall
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("rsw_fetch", e_fetch(1));
    cyc("rsw_decode", e_decode(0));
    cyc("rsw_memadr", e_memadr());
    mem_ready = 1'b0;
    cyc("rsw_memwrite_stall", e_memwrite());
    rst_n = 1'b0;
    cyc("rsw_reset1", '0);
    cyc("rsw_reset2", '0);
    cyc("rsw_reset3", '0);
    rst_n = 1'b1;
    cyc("rsw_post_fetch_stall", e_fetch(0));
    mem_ready = 1'b1;
    cyc("rsw_post_fetch", e_fetch(1));
    cyc("rsw_post_decode", e_decode(0));
    cyc("rsw_post_memadr", e_memadr());
    cyc("rsw_post_memwrite", e_memwrite());
    cyc("rsw_back_to_fetch", e_fetch(1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main controller for the multicycle RV32I-subset core. It sits directly upstream of the ALU and drives `alucontrol[2:0]` together with all datapath mux selects and write enables.
- It consumes the ALU `zero` flag to resolve `beq`.
- Moore FSM plus an embedded ALU decoder. Memory accesses stall on a `mem_ready` handshake.

Parameters:
- `STATE_W`, 4: width of the `state_dbg` output; must be ≥4.
- `ALUCTRL_W`, 3: width of `alucontrol`; fixed at 3 to match the ALU encoding.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous active-low reset.
- `opcode`, input, 7: `instr[6:0]` from the instruction register.
- `funct3`, input, 3: `instr[14:12]`.
- `funct7b5`, input, 1: `instr[30]`.
- `zero`, input, 1: ALU zero flag.
- `mem_ready`, input, 1: memory completes the current access this cycle.
- `pcwrite`, output, 1: PC register enable.
- `adrsrc`, output, 1: memory address select (0 = PC, 1 = ALUOut).
- `memwrite`, output, 1: data memory write strobe.
- `irwrite`, output, 1: instruction register enable.
- `regwrite`, output, 1: register file write enable.
- `resultsrc`, output, 2: result mux select (00 ALUOut, 01 ReadData, 10 ALUResult).
- `alusrca`, output, 2: ALU A select (00 PC, 01 OldPC, 10 rs1).
- `alusrcb`, output, 2: ALU B select (00 rs2, 01 ImmExt, 10 constant 4).
- `alucontrol`, output, 3: ALU operation (000 add, 001 sub, 010 and, 011 or).
- `illegal`, output, 1: one-cycle pulse in DECODE when the opcode is unsupported.
- `state_dbg`, output, `STATE_W`: current state encoding.

Behaviour:
- **Reset**
  - `rst_n` low at a rising edge sets state to FETCH (0) on that edge.
  - While `rst_n` is low, all outputs are forced to 0 combinationally, including `state_dbg`.
  - Reset mid-instruction abandons it; no enable fires in the reset cycle.
- **State encodings**
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10.
  - Unused codes go to FETCH.
- **Outputs per state** (unlisted outputs are 0; `aluop` is internal)
  - FETCH: `alusrca`=00, `alusrcb`=10, `resultsrc`=10, `aluop`=00. `irwrite`=`mem_ready`; `pcwrite`=`mem_ready`.
  - DECODE: `alusrca`=01, `alusrcb`=01, `aluop`=00 (branch target into ALUOut).
  - MEMADR: `alusrca`=10, `alusrcb`=01, `aluop`=00.
  - MEMREAD: `adrsrc`=1.
  - MEMWB: `resultsrc`=01, `regwrite`=1.
  - MEMWRITE: `adrsrc`=1, `memwrite`=1. `memwrite` is held until `mem_ready`.
  - EXECR: `alusrca`=10, `alusrcb`=00, `aluop`=10.
  - EXECI: `alusrca`=10, `alusrcb`=01, `aluop`=10.
  - ALUWB: `resultsrc`=00, `regwrite`=1.
  - BEQ: `alusrca`=10, `alusrcb`=00, `aluop`=01, `resultsrc`=00. `pcwrite`=`zero`.
  - JAL: `alusrca`=01, `alusrcb`=10, `aluop`=00, `resultsrc`=00, `pcwrite`=1.
- **Transitions**
  - FETCH → DECODE when `mem_ready`=1; otherwise stay in FETCH.
  - DECODE by opcode:
    - 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - Any other opcode → FETCH with `illegal`=1 for that cycle.
  - MEMADR → MEMREAD if lw, MEMWRITE if sw. Opcode is stable because IR holds it.
  - MEMREAD → MEMWB when `mem_ready`; else stay.
  - MEMWRITE → FETCH when `mem_ready`; else stay.
  - MEMWB → FETCH.
  - EXECR → ALUWB; EXECI → ALUWB; JAL → ALUWB; ALUWB → FETCH.
  - BEQ → FETCH.
- **ALU decoder** (combinational from `aluop`, `funct3`, `funct7b5`, `opcode[5]`)
  - `aluop`=00 → 000 (add).
  - `aluop`=01 → 001 (sub).
  - `aluop`=10, by `funct3`:
    - 000: 001 if `opcode[5]` & `funct7b5` (R-type sub), else 000.
    - 110: 011 (or).
    - 111: 010 (and).
    - Other `funct3`: 000.
  - `aluop`=11 is unused → 000.
- **Latencies (cycles, `mem_ready` always 1)**
  - lw: 5. sw: 4.
  - R-type, I-type, jal: 4.
  - beq: 3.
  - Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- **Other rules**
  - `zero` is sampled only in BEQ. A `zero` glitch in any other state has no effect.
  - All state-output decode is combinational from registered state. No output is registered.

Test Plan:
- Hold `rst_n`=0 for 3 cycles in the middle of a MEMWRITE stall.
  - During reset: all outputs 0.
  - After release: `state_dbg`=0 and `memwrite` stays 0 until MEMWRITE is re-entered.
- Run lw (`opcode` 0000011) with `mem_ready`=1.
  - State sequence 0,1,2,3,4,0.
  - `regwrite`=1 only in state 4, with `resultsrc`=01.
  - `adrsrc`=1 in state 3.
- Run R-type sub (`opcode` 0110011, `funct3` 000, `funct7b5`=1) → `alucontrol`=001 in EXECR.
  - Same fields with `opcode` 0010011 (addi) → `alucontrol`=000.
  - `funct3` 111 → 010; `funct3` 110 → 011.
- Run beq twice.
  - With `zero`=1: `pcwrite`=1 in BEQ and `alucontrol`=001.
  - With `zero`=0: `pcwrite`=0.
  - Both runs return to FETCH after 3 cycles total.
- Run sw with `mem_ready` low for 2 cycles in MEMWRITE.
  - `memwrite`=1 for 3 consecutive cycles, then FETCH.
  - FETCH with `mem_ready`=0 holds `irwrite`=`pcwrite`=0.
- Present `opcode` 1110011 (unsupported) → DECODE pulses `illegal`=1 for 1 cycle, next state FETCH, no `regwrite`/`memwrite`.
